// File: rtl/div_tick_ctrl.sv
// Single-clock tick scheduler: emits tick clock-enables every N cycles for a programmed burst.
// Define DIV_TICK_CTRL_SQUARE_EN to build the div_out square-wave flop (otherwise div_out is 0).
module div_tick_ctrl #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             done,
  output logic             div_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_reg, div_nxt;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic [CNT_W-1:0] cnt_reg, cnt_nxt;
  logic [CNT_W-1:0] tcnt_nxt;
  logic             last_tick;

  always_comb begin
    state_nxt = state;
    div_nxt   = div_reg;
    cnt_nxt   = cnt_reg;
    presc_nxt = presc;
    tcnt_nxt  = tick_cnt;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    tick      = 1'b0;
    last_tick = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          div_nxt = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
          cnt_nxt = cfg_count;
        end
        if (start) begin
          state_nxt = RUN;
          presc_nxt = '0;
          tcnt_nxt  = '0;
        end
      end
      RUN: begin
        busy      = 1'b1;
        tick      = (presc == div_reg - DIV_W'(1));
        last_tick = tick && (cnt_reg != '0) && (tick_cnt == cnt_reg - CNT_W'(1));
        // stop wins over completion: the tick still counts but done is withheld
        done      = last_tick && !stop;
        presc_nxt = tick ? '0 : presc + DIV_W'(1);
        if (tick) tcnt_nxt = tick_cnt + CNT_W'(1);
        if (stop || last_tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_reg  <= DIV_W'(1);
      cnt_reg  <= '0;
      presc    <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      div_reg  <= div_nxt;
      cnt_reg  <= cnt_nxt;
      presc    <= presc_nxt;
      tick_cnt <= tcnt_nxt;
    end
  end

`ifdef DIV_TICK_CTRL_SQUARE_EN
  logic sq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        sq <= 1'b0;
    else if (state == IDLE && start) sq <= 1'b0;
    else if (tick)                  sq <= ~sq;
  end

  assign div_out = sq;
`else
  assign div_out = 1'b0;
`endif

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Self-checking bench for div_tick_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_div_tick_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic [3:0] cfg_count;
  logic       start;
  logic       stop;
  logic       busy;
  logic       tick;
  logic [3:0] tick_cnt;
  logic       done;
  logic       div_out;

  div_tick_ctrl #(.DIV_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_count(cfg_count), .start(start), .stop(stop),
    .busy(busy), .tick(tick), .tick_cnt(tick_cnt), .done(done), .div_out(div_out)
  );

  always #5 clk = ~clk;

  logic [8:0] dut_vec;
  assign dut_vec = {busy, cfg_ready, tick, done, tick_cnt, div_out};

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model: m_cyc counts RUN cycles since start (1-based); a tick falls on every multiple of the divisor.
  bit          m_busy;
  int unsigned m_div, m_cnt, m_cyc, m_tcnt;
  bit          m_dout;

  task automatic model_reset();
    m_busy = 1'b0; m_div = 1; m_cnt = 0; m_cyc = 0; m_tcnt = 0; m_dout = 1'b0;
  endtask

  function automatic bit exp_tick();
    return m_busy && (m_cyc % m_div == 0);
  endfunction

  function automatic bit exp_done();
    return exp_tick() && (m_cnt != 0) && ((m_tcnt + 1) % 16 == m_cnt) && !stop;
  endfunction

  function automatic logic [8:0] exp_vec();
    logic dv;
`ifdef DIV_TICK_CTRL_SQUARE_EN
    dv = m_dout;
`else
    dv = 1'b0;
`endif
    return {m_busy, !m_busy, exp_tick(), exp_done(), 4'(m_tcnt), dv};
  endfunction

  task automatic model_edge();
    bit t;
    t = exp_tick();
    if (!m_busy) begin
      if (cfg_valid) begin
        m_div = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_cnt = int'(cfg_count);
      end
      if (start) begin
        m_busy = 1'b1; m_cyc = 1; m_tcnt = 0; m_dout = 1'b0;
      end
    end else begin
      if (t) begin
        m_tcnt = (m_tcnt + 1) % 16;
        m_dout = !m_dout;
      end
      if (stop || (t && m_cnt != 0 && m_tcnt == m_cnt)) m_busy = 1'b0;
      else m_cyc++;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_count = '0; start = 1'b0; stop = 1'b0;
    model_reset();
    #3;
    n_cmp++;
    if (dut_vec !== 9'b010000000) begin
      n_bad++; $display("FAIL reset_init: got %b want %b", dut_vec, 9'b010000000);
    end
    @(posedge clk); #1 rst = 1'b0;
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_count = 4'd0; start = 1'b1;
    clk_step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL reset_preburst c=%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      clk_step();
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec !== 9'b010000000) begin
      n_bad++; $display("FAIL reset_async: got %b want %b", dut_vec, 9'b010000000);
    end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec() || tick !== 1'b1) begin
        n_bad++; $display("FAIL reset_div1 c=%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      clk_step();
    end
    stop = 1'b1;
    clk_step();
    stop = 1'b0;
  endtask

  task automatic test_bounded();
    logic [22:0] mask;
    int unsigned done_at, idle_at;
    mask = '0; done_at = 0; idle_at = 0;
    cfg_valid = 1'b1; cfg_div = 8'd5; cfg_count = 4'd4;
    clk_step();
    cfg_valid = 1'b0; start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL bounded c=%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      if (tick) mask[c] = 1'b1;
      if (done && done_at == 0) done_at = c;
      if (!busy && idle_at == 0) idle_at = c;
      clk_step();
    end
    n_cmp++;
    if (mask !== 23'h108420 || done_at != 20 || idle_at != 21 || tick_cnt !== 4'd4) begin
      n_bad++;
      $display("FAIL bounded_timing: got mask=%h done=%0d idle=%0d cnt=%0d want mask=108420 done=20 idle=21 cnt=4",
               mask, done_at, idle_at, tick_cnt);
    end
  endtask

  task automatic test_div0_div1();
    logic [5:0] mask;
    int unsigned done_at;
    for (int d = 0; d <= 1; d++) begin
      mask = '0; done_at = 0;
      cfg_valid = 1'b1; cfg_div = 8'(d); cfg_count = 4'd3;
      clk_step();
      cfg_valid = 1'b0; start = 1'b1;
      clk_step();
      start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
          n_bad++; $display("FAIL div%0d c=%0d: got %b want %b", d, c, dut_vec, exp_vec());
        end
        if (tick) mask[c] = 1'b1;
        if (done && done_at == 0) done_at = c;
        clk_step();
      end
      n_cmp++;
      if (mask !== 6'b001110 || done_at != 3 || tick_cnt !== 4'd3 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL div%0d_trace: got mask=%b done=%0d cnt=%0d busy=%b want mask=001110 done=3 cnt=3 busy=0",
                 d, mask, done_at, tick_cnt, busy);
      end
    end
  endtask

  task automatic test_free_wrap();
    logic [3:0] cnt31, cnt33;
    bit saw_done;
    saw_done = 1'b0; cnt31 = '0; cnt33 = '0;
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_count = 4'd0; start = 1'b1;
    clk_step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 35) stop = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL free_wrap c=%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      if (done) saw_done = 1'b1;
      if (c == 31) cnt31 = tick_cnt;
      if (c == 33) cnt33 = tick_cnt;
      clk_step();
    end
    stop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cnt31 !== 4'd15 || cnt33 !== 4'd0 || saw_done || busy !== 1'b0 || tick_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL free_wrap_end: got c31=%0d c33=%0d done=%b busy=%b cnt=%0d want 15 0 0 0 1",
               cnt31, cnt33, saw_done, busy, tick_cnt);
    end
    clk_step();
  endtask

  task automatic test_stop_final();
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_count = 4'd2;
    clk_step();
    cfg_valid = 1'b0; start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      stop = (c == 6);
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL stop_final c=%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      clk_step();
    end
    stop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || tick_cnt !== 4'd2 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_final_end: got busy=%b ready=%b cnt=%0d done=%b want 0 1 2 0",
               busy, cfg_ready, tick_cnt, done);
    end
    clk_step();
  endtask

  task automatic test_handshake();
    int unsigned first1, first2;
    first1 = 0; first2 = 0;
    cfg_valid = 1'b1; cfg_div = 8'd4; cfg_count = 4'd2; start = 1'b1;
    clk_step();
    start = 1'b0; cfg_div = 8'd7; cfg_count = 4'd5;
    for (int c = 1; c <= 9; c++) begin
      start = (c == 9);
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL handshake_a c=%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      if (tick && first1 == 0) first1 = c;
      clk_step();
    end
    start = 1'b0; cfg_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL handshake_b c=%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      if (tick && first2 == 0) first2 = c;
      clk_step();
    end
    n_cmp++;
    if (first1 != 4 || first2 != 7) begin
      n_bad++; $display("FAIL handshake_first_tick: got %0d,%0d want 4,7", first1, first2);
    end
    stop = 1'b1;
    clk_step();
    stop = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      cfg_valid = ($urandom_range(0, 9) < 3);
      cfg_div   = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      cfg_count = 4'($urandom);
      start     = ($urandom_range(0, 4) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random c=%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      clk_step();
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b1;
    clk_step();
    stop = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL random_end: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_bounded();
    test_div0_div1();
    test_free_wrap();
    test_stop_final();
    test_handshake();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
